mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state encodings and port ids for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester ids; also the encoding of the last-granted flag.
    localparam logic CORE   = 1'b0;
    localparam logic LOADER = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick
//
// Ports:
//   req0   - request from requester 0 (core)
//   req1   - request from requester 1 (loader)
//   last   - id of the requester granted most recently
//   winner - id of the requester to grant (0 when nobody requests)
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // On a tie the port that was not served last wins; otherwise the lone
    // requester wins (req1 alone -> 1, req0 alone or none -> 0).
    assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port data memory between core and loader
//
// Ports:
//   clk, rst                          - clock; asynchronous active-low reset
//   c_req, c_we, c_addr, c_wdata      - core request, write select, address, write data
//   c_ack, c_rdata                    - core one-cycle completion pulse, read data
//   c_stall                           - core waiting (c_req & ~c_ack)
//   l_req, l_we, l_addr, l_wdata      - loader request, write select, address, write data
//   l_ack, l_rdata                    - loader one-cycle completion pulse, read data
//   mem_a, mem_wd, mem_we, mem_re     - memory address, write data and strobes
//   mem_rd                            - memory combinational read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_t state;
    arb_state_t state_next;

    logic last_gnt;
    logic lat_id;
    logic lat_we;
    logic pick;
    logic latch_en;

    rr_pick2 u_pick (
        .req0   (c_req),
        .req1   (l_req),
        .last   (last_gnt),
        .winner (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes and acks decode straight from the state register, so an
    // asynchronous reset during ACCESS drops mem_we without waiting for a clock.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        c_ack      = 1'b0;
        l_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (c_req || l_req) begin
                    latch_en   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_we     = lat_we;
                mem_re     = ~lat_we;
                state_next = RESP;
            end
            RESP: begin
                c_ack      = (lat_id == CORE);
                l_ack      = (lat_id == LOADER);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // mem_a / mem_wd are the latched request fields themselves, which is why
    // they keep their last values outside ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_a    <= '0;
            mem_wd   <= '0;
            lat_we   <= 1'b0;
            lat_id   <= CORE;
            last_gnt <= LOADER;
            c_rdata  <= '0;
            l_rdata  <= '0;
        end else begin
            if (latch_en) begin
                lat_id <= pick;
                if (pick == LOADER) begin
                    lat_we <= l_we;
                    mem_a  <= l_addr;
                    mem_wd <= l_wdata;
                end else begin
                    lat_we <= c_we;
                    mem_a  <= c_addr;
                    mem_wd <= c_wdata;
                end
            end
            if (mem_re) begin
                if (lat_id == CORE) begin
                    c_rdata <= mem_rd;
                end else begin
                    l_rdata <= mem_rd;
                end
            end
            if (state == RESP) begin
                last_gnt <= lat_id;
            end
        end
    end

    assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [15:0] c_addr = '0, c_wdata = '0;
    logic        l_req = 1'b0, l_we = 1'b0;
    logic [15:0] l_addr = '0, l_wdata = '0;
    logic [15:0] mem_rd = '0;
    logic        c_ack, l_ack, c_stall, mem_we, mem_re;
    logic [15:0] c_rdata, l_rdata, mem_a, mem_wd;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_ack   (c_ack),
        .c_rdata (c_rdata),
        .c_stall (c_stall),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_ack   (l_ack),
        .l_rdata (l_rdata),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
        .mem_re  (mem_re),
        .mem_rd  (mem_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [15:0] c_addr;
        logic [15:0] c_wdata;
        logic        l_req;
        logic        l_we;
        logic [15:0] l_addr;
        logic [15:0] l_wdata;
        logic [15:0] rd;
        logic        win;
    } vec_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] c_rd;
        logic [15:0] l_rd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_c_rdata = '0;
    logic [15:0] m_l_rdata = '0;
    vec_t        vecs[9];
    int          ack_cyc[4];
    logic        ack_port[4];
    int          n_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Push the expected outcome of a grant to the given port, updating the read-data model.
    task automatic push_exp(input logic port, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rd);
        exp_t e;
        if (!we) begin
            if (port) m_l_rdata = rd;
            else      m_c_rdata = rd;
        end
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.c_rd  = m_c_rdata;
        e.l_rd  = m_l_rdata;
        sb.push_back(e);
    endtask

    // Called just after the edge that starts the IDLE cycle in which the request is sampled.
    task automatic await_ack(input string tag);
        bit          got = 0;
        bit          acc = 0;
        logic        aw = 1'b0;
        logic [15:0] aa = '0;
        logic [15:0] ad = '0;
        exp_t        e;
        for (int cyc = 0; cyc < 8 && !got; cyc++) begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                acc = 1;
                aw  = mem_we;
                aa  = mem_a;
                ad  = mem_wd;
                chk({tag, ".strobe_excl"}, {31'd0, mem_we & mem_re}, 32'd0);
            end
            if (c_ack || l_ack) begin
                got = 1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s.unexpected_ack: got ack with empty scoreboard", tag);
                end else begin
                    e = sb.pop_front();
                    chk({tag, ".latency"}, cyc, 2);
                    chk({tag, ".c_ack"}, c_ack, e.port == 1'b0);
                    chk({tag, ".l_ack"}, l_ack, e.port == 1'b1);
                    chk({tag, ".access"}, {31'd0, acc}, 1);
                    chk({tag, ".mem_we"}, aw, e.we);
                    chk({tag, ".mem_a"}, aa, e.addr);
                    if (e.we) chk({tag, ".mem_wd"}, ad, e.wdata);
                    chk({tag, ".c_rdata"}, c_rdata, e.c_rd);
                    chk({tag, ".l_rdata"}, l_rdata, e.l_rd);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: no ack within 8 cycles", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             c_req c_we c_addr    c_wdata   l_req l_we l_addr    l_wdata   rd        win
        vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'hA5A5, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0031, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0F0F, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'h0050, 16'h1111, 1'b1, 1'b0, 16'h0060, 16'h0000, 16'h7777, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0060, 16'h0000, 16'h7777, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 16'h0000, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.c_ack", c_ack, 0);
        chk("rst.l_ack", l_ack, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_re", mem_re, 0);
        chk("rst.mem_a", mem_a, 0);
        chk("rst.mem_wd", mem_wd, 0);
        chk("rst.c_rdata", c_rdata, 0);
        chk("rst.l_rdata", l_rdata, 0);

        // Both requesters held high from reset: grants alternate core, loader, ...
        c_req = 1; c_we = 1; c_addr = 16'h0100; c_wdata = 16'h0A0A;
        l_req = 1; l_we = 1; l_addr = 16'h0200; l_wdata = 16'h0B0B;
        @(negedge clk);
        chk("rst_req.c_ack", c_ack, 0);
        chk("rst_req.mem_we", mem_we, 0);
        rst = 1;
        n_ack = 0;
        for (int cyc = 0; cyc < 20 && n_ack < 4; cyc++) begin
            @(negedge clk);
            if (c_ack || l_ack) begin
                ack_cyc[n_ack]  = cyc;
                ack_port[n_ack] = l_ack;
                n_ack++;
            end
        end
        chk("alt.count", n_ack, 4);
        for (int i = 0; i < n_ack; i++) chk($sformatf("alt.port%0d", i), ack_port[i], i % 2);
        for (int i = 1; i < n_ack; i++) chk($sformatf("alt.gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        @(posedge clk); #1;
        c_req = 0; l_req = 0;

        // Table-driven transactions; last grant so far was the loader
        for (int v = 0; v < 9; v++) begin
            c_req = vecs[v].c_req; c_we = vecs[v].c_we; c_addr = vecs[v].c_addr; c_wdata = vecs[v].c_wdata;
            l_req = vecs[v].l_req; l_we = vecs[v].l_we; l_addr = vecs[v].l_addr; l_wdata = vecs[v].l_wdata;
            mem_rd = vecs[v].rd;
            if (vecs[v].win) push_exp(1'b1, vecs[v].l_we, vecs[v].l_addr, vecs[v].l_wdata, vecs[v].rd);
            else             push_exp(1'b0, vecs[v].c_we, vecs[v].c_addr, vecs[v].c_wdata, vecs[v].rd);
            await_ack($sformatf("vec%0d", v));
            @(posedge clk); #1;
        end
        c_req = 0; l_req = 0;

        // Core request dropped during ACCESS still completes, no new grant follows
        c_req = 1; c_we = 0; c_addr = 16'h0070; mem_rd = 16'hCAFE;
        @(posedge clk); #1;
        c_req = 0;
        @(negedge clk);
        chk("drop.mem_re", mem_re, 1);
        chk("drop.mem_a", mem_a, 16'h0070);
        @(negedge clk);
        chk("drop.c_ack", c_ack, 1);
        chk("drop.l_ack", l_ack, 0);
        chk("drop.c_rdata", c_rdata, 16'hCAFE);
        chk("drop.c_stall", c_stall, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drop.quiet%0d", i), {mem_we, mem_re, c_ack, l_ack}, 0);
        end

        // Core waits while the loader is served
        @(posedge clk); #1;
        l_req = 1; l_we = 0; l_addr = 16'h0080; mem_rd = 16'h4242;
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 16'h0090; c_wdata = 16'h3333;
        @(negedge clk);
        chk("stall.l_access_re", mem_re, 1);
        chk("stall.l_access", c_stall, 1);
        @(negedge clk);
        chk("stall.l_ack", l_ack, 1);
        chk("stall.l_resp_c_ack", c_ack, 0);
        chk("stall.l_rdata", l_rdata, 16'h4242);
        chk("stall.l_resp", c_stall, 1);
        @(posedge clk); #1;
        l_req = 0;
        @(negedge clk);
        chk("stall.idle", c_stall, 1);
        @(negedge clk);
        chk("stall.c_access", c_stall, 1);
        chk("stall.c_mem_we", mem_we, 1);
        chk("stall.c_mem_a", mem_a, 16'h0090);
        chk("stall.c_mem_wd", mem_wd, 16'h3333);
        @(negedge clk);
        chk("stall.c_ack", c_ack, 1);
        chk("stall.c_resp", c_stall, 0);
        @(posedge clk); #1;
        c_req = 0;
        @(negedge clk);
        chk("stall.after", c_stall, 0);

        // Reset asserted mid-ACCESS
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 16'h00A0; c_wdata = 16'hDEAD;
        @(posedge clk); #2;
        chk("abort.mem_we_before", mem_we, 1);
        rst = 0;
        #1;
        chk("abort.mem_we", mem_we, 0);
        chk("abort.mem_re", mem_re, 0);
        chk("abort.mem_a", mem_a, 0);
        c_req = 0;
        m_c_rdata = '0;
        m_l_rdata = '0;
        @(negedge clk);
        chk("abort.c_ack0", c_ack, 0);
        @(negedge clk);
        chk("abort.c_ack1", c_ack, 0);
        chk("abort.l_ack1", l_ack, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("abort.idle_c_ack", c_ack, 0);
        c_req = 1; c_we = 0; c_addr = 16'h00B0;
        l_req = 1; l_we = 0; l_addr = 16'h00C0;
        mem_rd = 16'h9999;
        push_exp(1'b0, 1'b0, 16'h00B0, 16'h0000, 16'h9999);
        await_ack("post_rst.core");
        @(posedge clk); #1;
        c_req = 0;
        mem_rd = 16'h6666;
        push_exp(1'b1, 1'b0, 16'h00C0, 16'h0000, 16'h6666);
        await_ack("post_rst.loader");
        @(posedge clk); #1;
        l_req = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
